// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: FSM encoding, op codes and width defaults shared by the regfile arbiter
package regfile_arb_pkg;
    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on contention the requester not granted last time wins
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    assign gnt    = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
    assign gnt_id = gnt[1];
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin access sequencer for the 4x4 register file (optional grant counters via ARB_STATS_EN)
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] mem_dbus,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rwb,
  input  logic [DATA_W-1:0] mem_qout
`ifdef ARB_STATS_EN
  , output logic [STAT_W-1:0] grant_cnt0
  , output logic [STAT_W-1:0] grant_cnt1
`endif
);
  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              rwb_q, rwb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dbus_q, dbus_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        gnt;
  logic              gnt_id;
  logic              accept;
  rr_arb2 u_arb (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .gnt       (gnt),
    .gnt_id    (gnt_id)
  );
  assign req_ready = (state_q == S_IDLE && !rst) ? gnt : 2'b00;
  assign accept    = |req_ready;
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    rwb_d        = 1'b0;
    addr_d       = addr_q;
    dbus_d       = dbus_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d      = S_ACCESS;
        last_grant_d = gnt_id;
        id_d         = gnt_id;
        we_d         = req_we[gnt_id];
        rwb_d        = req_we[gnt_id] == OP_WRITE;
        addr_d       = gnt_id ? req_addr1 : req_addr0;
        dbus_d       = gnt_id ? req_wdata1 : req_wdata0;
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = id_q ? 2'b10 : 2'b01;
        rsp_rdata_d = (we_q == OP_READ) ? mem_qout : dbus_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      rwb_q        <= 1'b0;
      addr_q       <= '0;
      dbus_q       <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      rwb_q        <= rwb_d;
      addr_q       <= addr_d;
      dbus_q       <= dbus_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end
  assign mem_rwb     = rwb_q;
  assign mem_address = addr_q;
  assign mem_dbus    = dbus_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_q + STAT_W'(accept && !gnt_id && !(&cnt0_q));
      cnt1_q <= cnt1_q + STAT_W'(accept && gnt_id && !(&cnt1_q));
    end
  end
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed checks of arbitration, access timing and reset recovery against a register-file model
module tb_regfile_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [1:0] req_addr0, req_addr1, mem_address;
  logic [3:0] req_wdata0, req_wdata1, rsp_rdata, mem_dbus, mem_qout;
  logic       mem_rwb;
  logic [3:0] mem [4];
  int         n_vec = 0;
  int         n_err = 0;
`ifdef ARB_STATS_EN
  logic [1:0] grant_cnt0, grant_cnt1;
`endif
  always #5 clk = ~clk;
  regfile_arbiter #(.STAT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_dbus   (mem_dbus),
    .mem_address(mem_address),
    .mem_rwb    (mem_rwb),
    .mem_qout   (mem_qout)
`ifdef ARB_STATS_EN
    , .grant_cnt0(grant_cnt0)
    , .grant_cnt1(grant_cnt1)
`endif
  );
  assign mem_qout = mem[mem_address];
  always @(posedge clk) begin
    if (rst) mem <= '{4'h3, 4'h6, 4'h9, 4'hC};
    else if (mem_rwb) mem[mem_address] <= mem_dbus;
  end
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int id, input logic we, input logic [1:0] a, input logic [3:0] d);
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    if (id == 0) begin
      req_addr0  = a;
      req_wdata0 = d;
    end else begin
      req_addr1  = a;
      req_wdata1 = d;
    end
  endtask
  task automatic xfer(input int id, input logic we, input logic [1:0] a, input logic [3:0] d,
                      input logic [3:0] exp);
    int         n;
    logic [1:0] b;
    n = 0;
    b = (id == 1) ? 2'b10 : 2'b01;
    drive(id, we, a, d);
    #1;
    while (!req_ready[id] && n < 10) begin
      tick();
      n++;
    end
    check("ready_wait", 8'(req_ready), 8'(b));
    tick();
    req_valid[id] = 1'b0;
    check("access_rwb", 8'(mem_rwb), 8'(we));
    check("access_addr", 8'(mem_address), 8'(a));
    check("access_dbus", 8'(mem_dbus), 8'(d));
    check("access_ready", 8'(req_ready), 8'd0);
    tick();
    check("resp_valid", 8'(rsp_valid), 8'(b));
    check("resp_rdata", 8'(rsp_rdata), 8'(exp));
    check("resp_rwb", 8'(mem_rwb), 8'd0);
    tick();
    check("resp_clear", 8'(rsp_valid), 8'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] eb;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_we     = 2'b00;
    req_addr0  = 2'd0;
    req_addr1  = 2'd1;
    req_wdata0 = 4'h0;
    req_wdata1 = 4'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", 8'(req_ready), 8'd0);
      check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
      check("rst_rdata", 8'(rsp_rdata), 8'd0);
      check("rst_dbus", 8'(mem_dbus), 8'd0);
      check("rst_addr", 8'(mem_address), 8'd0);
      check("rst_rwb", 8'(mem_rwb), 8'd0);
    end
    rst = 1'b0;
    #1;
    for (int t = 0; t < 12; t++) begin
      eb = ((t / 3) % 2 == 1) ? 2'b10 : 2'b01;
      check("rr_ready", 8'(req_ready), (t % 3 == 0) ? 8'(eb) : 8'd0);
      check("rr_rsp", 8'(rsp_valid), (t % 3 == 2) ? 8'(eb) : 8'd0);
      check("rr_rwb", 8'(mem_rwb), 8'd0);
      if (t % 3 == 2) check("rr_rdata", 8'(rsp_rdata), eb[1] ? 8'h6 : 8'h3);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("idle_ready", 8'(req_ready), 8'd0);
    tick();
    check("idle_rsp", 8'(rsp_valid), 8'd0);
    xfer(0, 1'b1, 2'd2, 4'hA, 4'hA);
    xfer(0, 1'b0, 2'd2, 4'h0, 4'hA);
    xfer(1, 1'b1, 2'd3, 4'h5, 4'h5);
    xfer(1, 1'b0, 2'd1, 4'h0, 4'h6);
    xfer(0, 1'b0, 2'd3, 4'h0, 4'h5);
    xfer(0, 1'b0, 2'd0, 4'h0, 4'h3);
    xfer(0, 1'b0, 2'd2, 4'h0, 4'hA);
    drive(0, 1'b0, 2'd0, 4'h0);
    #1;
    check("mid_ready", 8'(req_ready), 8'd1);
    tick();
    rst       = 1'b1;
    req_valid = 2'b00;
    tick();
    check("mid_rsp", 8'(rsp_valid), 8'd0);
    check("mid_rwb", 8'(mem_rwb), 8'd0);
    req_valid = 2'b01;
    #1;
    check("mid_ready_rst", 8'(req_ready), 8'd0);
    rst = 1'b0;
    #1;
    check("mid_ready_back", 8'(req_ready), 8'd1);
    req_valid = 2'b00;
    tick();
    check("mid_rsp_after", 8'(rsp_valid), 8'd0);
    check("mid_rwb_after", 8'(mem_rwb), 8'd0);
`ifdef ARB_STATS_EN
    for (int k = 1; k <= 5; k++) begin
      xfer(1, 1'b0, 2'd0, 4'h0, 4'h3);
      check("cnt1", 8'(grant_cnt1), (k < 3) ? 8'(k) : 8'd3);
      check("cnt0", 8'(grant_cnt0), 8'd0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
